// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch unit, transmitting end of the IFU->IDU interface.
// Holds the architectural PC, fetches one instruction per PC over an
// AXI-lite style AR/R read channel, presents {instruction, pc} to the decoder
// under valid/ready, then waits for the decoder's resolved next PC.
// Only one instruction is ever in flight.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   araddr/arvalid/arready   read-address channel (araddr word aligned)
//   rdata/rresp/rvalid/rready read-data channel
//   instruction/pc           latched instruction and its PC to the decoder
//   ifu_send_valid/idu_ready decoder handshake
//   pc_next/pc_write_enable  resolved next PC and its one-cycle strobe
//   fetch_error              sticky flag: bad rresp or misaligned PC seen
module ifu_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter logic [31:0] ERR_INSTR = 32'h0010_0073
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        ifu_send_valid,
  input  logic        idu_ready,
  input  logic [31:0] pc_next,
  input  logic        pc_write_enable,
  output logic        fetch_error
);

  typedef enum logic [1:0] {ADDR, DATA, SEND, WAIT_PC} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ADDR;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    err_d          = err_q;
    pend_d         = pend_q;
    pend_pc_d      = pend_pc_q;
    arvalid        = 1'b0;
    rready         = 1'b0;
    ifu_send_valid = 1'b0;

    // A redirect arriving before WAIT_PC is parked; the latest one wins.
    if (pc_write_enable && state_q != WAIT_PC) begin
      pend_d    = 1'b1;
      pend_pc_d = pc_next;
    end

    unique case (state_q)
      ADDR: begin
        arvalid = !rst;
        if (arready) state_d = DATA;
      end
      DATA: begin
        rready = !rst;
        if (rvalid) begin
          if (rresp == 2'b00 && pc_q[1:0] == 2'b00) begin
            instr_d = rdata;
          end else begin
            instr_d = ERR_INSTR;
            err_d   = 1'b1;
          end
          state_d = SEND;
        end
      end
      SEND: begin
        ifu_send_valid = !rst;
        if (idu_ready) state_d = WAIT_PC;
      end
      WAIT_PC: begin
        // A live strobe takes priority over a parked redirect.
        if (pc_write_enable) begin
          pc_d    = pc_next;
          pend_d  = 1'b0;
          state_d = ADDR;
        end else if (pend_q) begin
          pc_d    = pend_pc_q;
          pend_d  = 1'b0;
          state_d = ADDR;
        end
      end
      default: state_d = ADDR;
    endcase
  end

  assign araddr      = {pc_q[31:2], 2'b00};
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign fetch_error = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] ERR_INSTR = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        ifu_send_valid;
  logic        idu_ready = 1'b0;
  logic [31:0] pc_next = '0;
  logic        pc_write_enable = 1'b0;
  logic        fetch_error;

  ifu_fetch #(.RESET_PC(RESET_PC), .ERR_INSTR(ERR_INSTR)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .instruction(instruction), .pc(pc),
    .ifu_send_valid(ifu_send_valid), .idu_ready(idu_ready),
    .pc_next(pc_next), .pc_write_enable(pc_write_enable),
    .fetch_error(fetch_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_pc = RESET_PC;
  int          ar_hs = 0;
  int          send_hs = 0;

  always @(posedge clk) begin
    if (!rst && arvalid === 1'b1 && arready === 1'b1) ar_hs++;
    if (!rst && ifu_send_valid === 1'b1 && idu_ready === 1'b1) send_hs++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for arvalid, checks the address and completes the AR handshake.
  task automatic drive_ar;
    bit done = 1'b0;
    arready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (arvalid === 1'b1) begin
        checks++;
        if (araddr !== {model_pc[31:2], 2'b00}) begin
          errors++;
          $display("FAIL araddr got %h expected %h", araddr, {model_pc[31:2], 2'b00});
        end
        done = 1'b1;
      end
      tick;
    end
    arready = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL ar_timeout arvalid got %b expected 1", arvalid);
    end
  endtask

  // Returns read data after rwait cycles and records the expected delivery.
  task automatic drive_r(input logic [31:0] data, input logic [1:0] resp, input int rwait);
    exp_t e;
    rvalid = 1'b0;
    repeat (rwait) tick;
    checks++;
    if (rready !== 1'b1) begin
      errors++;
      $display("FAIL rready got %b expected 1", rready);
    end
    rdata  = data;
    rresp  = resp;
    rvalid = 1'b1;
    e.instr = (resp == 2'b00 && model_pc[1:0] == 2'b00) ? data : ERR_INSTR;
    e.pc    = model_pc;
    exp_q.push_back(e);
    tick;
    rvalid = 1'b0;
    rdata  = '0;
    rresp  = '0;
  endtask

  // Holds idu_ready low for hold cycles, then accepts; optional same-cycle strobe.
  task automatic accept(input int hold, input bit strobe, input logic [31:0] spc);
    bit   seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (ifu_send_valid === 1'b1) seen = 1'b1;
      else tick;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ifu_send_valid got %b expected 1", ifu_send_valid);
      return;
    end
    idu_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick;
      checks++;
      if (ifu_send_valid !== 1'b1 || exp_q.size() == 0 ||
          instruction !== exp_q[0].instr || pc !== exp_q[0].pc) begin
        errors++;
        $display("FAIL send_stall valid=%b instr=%h pc=%h expected valid=1 and queued head",
                 ifu_send_valid, instruction, pc);
      end
    end
    idu_ready = 1'b1;
    if (strobe) begin
      pc_write_enable = 1'b1;
      pc_next         = spc;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty instr=%h pc=%h expected nothing", instruction, pc);
    end else begin
      e = exp_q.pop_front();
      if (instruction !== e.instr) begin
        errors++;
        $display("FAIL instruction got %h expected %h", instruction, e.instr);
      end
      checks++;
      if (pc !== e.pc) begin
        errors++;
        $display("FAIL pc got %h expected %h", pc, e.pc);
      end
    end
    tick;
    idu_ready       = 1'b0;
    pc_write_enable = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] npc);
    pc_write_enable = 1'b1;
    pc_next         = npc;
    tick;
    pc_write_enable = 1'b0;
    model_pc        = npc;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) tick;
    checks++;
    if (arvalid !== 1'b0 || ifu_send_valid !== 1'b0 || rready !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs arvalid=%b send=%b rready=%b expected 0 0 0",
               arvalid, ifu_send_valid, rready);
    end
    checks++;
    if (pc !== RESET_PC || fetch_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pc=%h err=%b expected %h 0", pc, fetch_error, RESET_PC);
    end
    rst = 1'b0;
    model_pc = RESET_PC;
    tick;
    checks++;
    if (arvalid !== 1'b1 || araddr !== RESET_PC) begin
      errors++;
      $display("FAIL first_ar arvalid=%b araddr=%h expected 1 %h", arvalid, araddr, RESET_PC);
    end
  endtask

  task automatic test_basic_fetch;
    drive_ar();
    drive_r(32'h0000_0513, 2'b00, 2);
    accept(0, 1'b0, '0);
    checks++;
    if (arvalid !== 1'b0) begin
      errors++;
      $display("FAIL bubble arvalid got %b expected 0", arvalid);
    end
    redirect(32'h8000_0004);
  endtask

  task automatic test_backpressure;
    int ar0;
    int s0;
    ar0 = ar_hs;
    s0  = send_hs;
    arready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (arvalid !== 1'b1 || araddr !== {model_pc[31:2], 2'b00}) begin
        errors++;
        $display("FAIL ar_stall arvalid=%b araddr=%h expected 1 %h", arvalid, araddr, model_pc);
      end
    end
    drive_ar();
    drive_r(32'h00a0_0093, 2'b00, 0);
    accept(4, 1'b0, '0);
    checks++;
    if (ar_hs - ar0 != 1 || send_hs - s0 != 1) begin
      errors++;
      $display("FAIL handshake_count ar=%0d send=%0d expected 1 1", ar_hs - ar0, send_hs - s0);
    end
    redirect(32'h8000_0008);
  endtask

  task automatic test_early_redirect;
    drive_ar();
    // Early strobe while in DATA, before read data returns.
    pc_write_enable = 1'b1;
    pc_next         = 32'h8000_0100;
    tick;
    pc_write_enable = 1'b0;
    drive_r(32'h0010_0113, 2'b00, 0);
    // Second strobe in the same cycle as the SEND handshake.
    accept(0, 1'b1, 32'h8000_0200);
    checks++;
    if (arvalid !== 1'b0) begin
      errors++;
      $display("FAIL wait_pc_cycle arvalid got %b expected 0", arvalid);
    end
    tick;
    checks++;
    if (arvalid !== 1'b1) begin
      errors++;
      $display("FAIL wait_pc_one_cycle arvalid got %b expected 1", arvalid);
    end
    model_pc = 32'h8000_0200;
    drive_ar();
    drive_r(32'h0020_0193, 2'b00, 1);
    accept(0, 1'b0, '0);
    redirect(32'h8000_0204);
  endtask

  task automatic test_fetch_error;
    drive_ar();
    checks++;
    if (fetch_error !== 1'b0) begin
      errors++;
      $display("FAIL error_clear got %b expected 0", fetch_error);
    end
    drive_r(32'h1234_5678, 2'b10, 0);
    accept(0, 1'b0, '0);
    checks++;
    if (fetch_error !== 1'b1) begin
      errors++;
      $display("FAIL error_rresp got %b expected 1", fetch_error);
    end
    redirect(32'h8000_0006);
    drive_ar();
    drive_r(32'h1111_1111, 2'b00, 0);
    accept(0, 1'b0, '0);
    redirect(32'h8000_000c);
    drive_ar();
    drive_r(32'h0030_0213, 2'b00, 0);
    accept(0, 1'b0, '0);
    checks++;
    if (fetch_error !== 1'b1) begin
      errors++;
      $display("FAIL error_sticky got %b expected 1", fetch_error);
    end
    redirect(32'h8000_0010);
  endtask

  task automatic test_reset_mid_read;
    int s0;
    drive_ar();
    rst = 1'b1;
    repeat (2) tick;
    checks++;
    if (fetch_error !== 1'b0 || pc !== RESET_PC || rready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read err=%b pc=%h rready=%b expected 0 %h 0",
               fetch_error, pc, rready, RESET_PC);
    end
    rst = 1'b0;
    model_pc = RESET_PC;
    s0 = send_hs;
    idu_ready = 1'b1;
    repeat (2) tick;
    rdata  = 32'hdead_beef;
    rresp  = 2'b00;
    rvalid = 1'b1;
    tick;
    rvalid = 1'b0;
    rdata  = '0;
    repeat (2) tick;
    idu_ready = 1'b0;
    checks++;
    if (ifu_send_valid !== 1'b0 || arvalid !== 1'b1 || send_hs != s0) begin
      errors++;
      $display("FAIL stale_rvalid send=%b arvalid=%b sends=%0d expected 0 1 0",
               ifu_send_valid, arvalid, send_hs - s0);
    end
    drive_ar();
    drive_r(32'h0000_0013, 2'b00, 0);
    accept(0, 1'b0, '0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_early_redirect();
    test_fetch_error();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
